fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage for the single-cycle CPU. It sits directly upstream of the instruction decoder/controller.
- Owns the PC register.
- Issues requests to instruction memory over a variable-latency req/ack handshake.
- Holds the fetched instruction stable for the decoder until execute commits it.
- Consumes the decoder's nextpc_mux select, immediate and source-1 register data to form the next PC.

Parameters:
INST_BIT_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC and instruction-memory address width
RESET_PC, 32'h0000_0040, PC loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  instruction-memory read request
imem_addr  output  ADDR_WIDTH  byte address of the requested word (equals pc)
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  INST_BIT_WIDTH  returned instruction word
inst  output  INST_BIT_WIDTH  held instruction, drives the decoder input
inst_valid  output  1  inst is valid and awaiting commit
pc_out  output  ADDR_WIDTH  address of the held instruction
pc_plus4  output  ADDR_WIDTH  pc_out + 4, mod 2^ADDR_WIDTH
commit  input  1  execute retires the held instruction this cycle
nextpc_mux  input  2  next-PC select from decoder, sampled with commit
imm  input  16  decoder immediate, sampled with commit
src1_data  input  ADDR_WIDTH  register-file source-1 value, used by select 10
fault  output  1  sticky misaligned-target flag

Behaviour:
- Reset: rst_n low at a posedge sets the following, regardless of the current state, including mid-request:
  - pc=RESET_PC, state=IDLE
  - imem_req=0, inst=0, inst_valid=0, fault=0
- A pending ack after reset is discarded.
- States: IDLE, REQ, ISSUE, HALT. The state, imem_req, inst_valid and fault are registered.
- IDLE: the first cycle out of reset. Go to REQ next cycle.
- REQ:
  - imem_req=1, imem_addr=pc, held stable until ack.
  - If imem_ack=1 in a cycle where imem_req=1: inst<=imem_rdata, inst_valid<=1, go to ISSUE, imem_req<=0.
  - Otherwise stay in REQ (unbounded wait).
- ISSUE:
  - inst, pc_out and inst_valid are held stable.
  - On commit=1, compute the target:
    - sext = imm sign-extended to ADDR_WIDTH, shifted left 2.
    - nextpc_mux 00: pc+4.
    - nextpc_mux 01: pc+4+sext (taken branch).
    - nextpc_mux 10: src1_data+sext (JAL).
    - nextpc_mux 11: reserved, treated as 00.
  - All sums are mod 2^ADDR_WIDTH; wrap-around is silent.
  - If target[1:0]==0: pc<=target, inst_valid<=0, go to REQ.
  - Else: fault<=1, inst_valid<=0, pc unchanged, go to HALT.
- HALT: imem_req=0, inst_valid=0, fault=1. Sticky until reset.
- commit outside ISSUE is ignored. imem_ack outside REQ is ignored.
- Latency:
  - Commit in cycle N gives imem_req in N+1.
  - With a same-cycle ack, inst_valid=1 in N+2.
  - Reset release to first inst_valid takes a minimum of 3 cycles.
- pc_out=pc. pc_plus4 is combinational from pc.

Test Plan:
- Reset/first fetch: hold rst_n=0 for 2 cycles, release; ack in the first REQ cycle with rdata=32'h6C0F0004 -> imem_addr=0x40, inst=32'h6C0F0004, inst_valid=1 three cycles after release, pc_plus4=0x44.
- Stall: ack delayed 5 cycles -> imem_req stays 1, imem_addr stays 0x40, inst_valid=0 throughout; valid asserts the cycle after ack.
- Branch: pc=0x40, commit with nextpc_mux=01, imm=16'hFFFE -> next imem_addr=0x3C. Then commit with nextpc_mux=00 -> 0x40.
- JAL and wrap:
  - nextpc_mux=10, src1_data=0x100, imm=3 -> imem_addr=0x10C.
  - pc=0xFFFFFFFC, commit with nextpc_mux=00 -> imem_addr=0x0.
- Misaligned: nextpc_mux=10, src1_data=0x102, imm=0 -> fault=1, imem_req stays 0, further commits ignored until rst_n=0, which clears fault.
- Reset mid-request: rst_n=0 while in REQ with ack arriving the same cycle -> inst stays 0, inst_valid=0, pc=0x40 after reset.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency req/ack
// handshake, holds the instruction for the decoder and forms the next PC on commit.
module fetch_stage #(
  parameter int                      INST_BIT_WIDTH = 32,
  parameter int                      ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC       = ADDR_WIDTH'(32'h0000_0040)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_BIT_WIDTH-1:0]  imem_rdata,
  output logic [INST_BIT_WIDTH-1:0]  inst,
  output logic                       inst_valid,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic [ADDR_WIDTH-1:0]      pc_plus4,
  input  logic                       commit,
  input  logic [1:0]                 nextpc_mux,
  input  logic [15:0]                imm,
  input  logic [ADDR_WIDTH-1:0]      src1_data,
  output logic                       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    ISSUE = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
  logic [INST_BIT_WIDTH-1:0]   inst_q, inst_d;
  logic                        inst_valid_q, inst_valid_d;
  logic                        imem_req_q, imem_req_d;
  logic                        fault_q, fault_d;

  logic [ADDR_WIDTH-1:0]       seq_pc;
  logic [ADDR_WIDTH-1:0]       sext;
  logic [ADDR_WIDTH-1:0]       target;

  assign seq_pc = pc_q + FOUR;

  // Word offset: immediate counts instructions, so scale by 4 after sign extension.
  assign sext = ADDR_WIDTH'($signed(imm)) << 2;

  always_comb begin
    case (nextpc_mux)
      2'b01:   target = seq_pc + sext;
      2'b10:   target = src1_data + sext;
      default: target = seq_pc;
    endcase
  end

  // NOTE: every next-state signal gets its hold value first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    fault_d      = fault_q;

    case (state_q)
      IDLE: begin
        imem_req_d = 1'b1;
        state_d    = REQ;
      end

      REQ: begin
        if (imem_ack && imem_req_q) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (commit) begin
          inst_valid_d = 1'b0;
          if (target[1:0] == 2'b00) begin
            pc_d       = target;
            imem_req_d = 1'b1;
            state_d    = REQ;
          end else begin
            // Misaligned target: stop fetching and leave pc pointing at the culprit.
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end

      HALT: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
        fault_d      = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      // NOTE: the instruction holding register is reset too, so the decoder sees
      // a defined zero word rather than stale data after reset.
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc_out     = pc_q;
  assign pc_plus4   = seq_pc;
  assign fault      = fault_q;

endmodule
